// File: rtl/seven_seg_scan_n_if.sv
// Display/strobe bundle for the seven_seg_scan_n scanner: digit data in,
// multiplexed active-low display lines and timing strobes out.
interface seven_seg_scan_n_if #(
  parameter int N_DIG    = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*N_DIG-1:0]  dat;
  logic [N_DIG-1:0]    dp;
  logic [N_DIG-1:0]    blank;
  logic [BRIGHT_W-1:0] bright;
  logic [N_DIG-1:0]    AN;
  logic [6:0]          seg;
  logic                seg_P;
  logic                ce1ms;
  logic                ce10ms;

  modport master (
    output dat, dp, blank, bright,
    input  AN, seg, seg_P, ce1ms, ce10ms
  );

  modport slave (
    input  dat, dp, blank, bright,
    output AN, seg, seg_P, ce1ms, ce10ms
  );
endinterface

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed 7-segment scanner with frame snapshot, PWM brightness and
// ms/slow strobes. Define LZ_BLANK_EN to enable leading-zero suppression.
module seven_seg_scan_n #(
  parameter int N_DIG    = 4,
  parameter int FCLK     = 50000000,
  parameter int FSCAN    = 1000,
  parameter int FSLOW    = 100,
  parameter int BRIGHT_W = 4
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scan_n_if.slave bus
);
  localparam int DIV    = FCLK / FSCAN;
  localparam int SUB    = DIV >> BRIGHT_W;
  localparam int NSLOW  = FSCAN / FSLOW;
  localparam int CNT_W  = $clog2(DIV);
  localparam int IDX_W  = $clog2(N_DIG);
  localparam int SLOW_W = $clog2(NSLOW);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [SLOW_W-1:0]     slow;
  logic [N_DIG-1:0][3:0] dat_s;
  logic [N_DIG-1:0]      dp_s;
  logic [N_DIG-1:0]      blank_s;
  logic [N_DIG-1:0]      lz_dark;
  logic [BRIGHT_W-1:0]   bright_h;
  logic [BRIGHT_W-1:0]   phase;
  logic                  first;
  logic                  tick;
  logic                  last_dig;
  logic                  lit;
  logic [N_DIG-1:0]      an_d, an_q;
  logic [6:0]            seg_d, seg_q;
  logic                  segp_d, segp_q;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick     = (cnt == CNT_W'(DIV - 1));
  assign last_dig = (idx == IDX_W'(N_DIG - 1));
  assign phase    = BRIGHT_W'(cnt / CNT_W'(SUB));

`ifdef LZ_BLANK_EN
  logic lz_seen;

  // Scan from the top digit down; everything above the first non-zero
  // nibble or lit decimal point stays dark, digit 0 never does.
  always_comb begin
    lz_seen = 1'b0;
    lz_dark = '0;
    for (int unsigned j = 0; j < N_DIG; j++) begin
      if (dat_s[N_DIG-1-j] != 4'h0 || dp_s[N_DIG-1-j]) lz_seen = 1'b1;
      lz_dark[N_DIG-1-j] = ~lz_seen;
    end
    lz_dark[0] = 1'b0;
  end
`else
  assign lz_dark = '0;
`endif

  always_comb begin
    an_d   = '1;
    seg_d  = 7'h7F;
    segp_d = 1'b1;
    lit    = (phase <= bright_h) && !(blank_s[idx] || lz_dark[idx]);
    if (lit) begin
      an_d[idx] = 1'b0;
      seg_d     = hex7(dat_s[idx]);
      segp_d    = ~dp_s[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      slow     <= '0;
      dat_s    <= '0;
      dp_s     <= '0;
      blank_s  <= '0;
      bright_h <= '0;
      first    <= 1'b1;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      segp_q   <= 1'b1;
    end else begin
      first  <= 1'b0;
      an_q   <= an_d;
      seg_q  <= seg_d;
      segp_q <= segp_d;
      if (tick) begin
        cnt  <= '0;
        idx  <= last_dig ? '0 : idx + 1'b1;
        slow <= (slow == SLOW_W'(NSLOW - 1)) ? '0 : slow + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Capture on the first cycle out of reset so frame 0 shows live data.
      if (first || (tick && last_dig)) begin
        dat_s   <= bus.dat;
        dp_s    <= bus.dp;
        blank_s <= bus.blank;
      end
      if (first || tick) bright_h <= bus.bright;
    end
  end

  assign bus.AN     = an_q;
  assign bus.seg    = seg_q;
  assign bus.seg_P  = segp_q;
  assign bus.ce1ms  = tick;
  assign bus.ce10ms = tick && (slow == SLOW_W'(NSLOW - 1));
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Scoreboard bench for seven_seg_scan_n: a time-based reference model pushes the
// expected per-cycle outputs, an independent monitor pops and compares them.
module tb_seven_seg_scan_n;
  localparam int N    = 4;
  localparam int BW   = 2;
  localparam int FCLK = 160;
  localparam int FSC  = 10;
  localparam int FSL  = 1;
  localparam int DIV  = FCLK / FSC;
  localparam int SUB  = DIV >> BW;
  localparam int R    = FSC / FSL;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       segp;
    logic       ce1;
    logic       ce10;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_n_if #(.N_DIG(N), .BRIGHT_W(BW)) bus ();

  seven_seg_scan_n #(
    .N_DIG(N), .FCLK(FCLK), .FSCAN(FSC), .FSLOW(FSL), .BRIGHT_W(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        v_rst = 1'b1;
  logic [15:0] v_dat = '0;
  logic [3:0]  v_dp = '0, v_blank = '0;
  logic [1:0]  v_bright = '0;

  // Model state: edges since reset plus the frame/slot-held copies of the inputs.
  int unsigned k = 0;
  logic [15:0] s_dat = '0;
  logic [3:0]  s_dp = '0, s_blank = '0;
  logic [1:0]  s_bright = '0;

  task automatic model();
    exp_t        x;
    int unsigned e, c, id, ph;
    logic        dark;
    logic [3:0]  nb;
    if (v_rst) begin
      x = '{an: 4'hF, seg: 7'h7F, segp: 1'b1, ce1: 1'b0, ce10: 1'b0};
      k = 0; s_dat = '0; s_dp = '0; s_blank = '0; s_bright = '0;
    end else begin
      e  = k + 1;
      c  = (e - 1) % DIV;
      id = ((e - 1) / DIV) % N;
      ph = c / SUB;
      dark = s_blank[id];
`ifdef LZ_BLANK_EN
      begin
        int unsigned top = 0;
        for (int unsigned i = 0; i < N; i++) begin
          nb = 4'(s_dat >> (4 * i));
          if (nb != 4'h0 || s_dp[i]) top = i;
        end
        if (id > top) dark = 1'b1;
      end
`endif
      nb = 4'(s_dat >> (4 * id));
      if (ph <= s_bright && !dark) begin
        x.an = 4'hF; x.an[id] = 1'b0;
        x.seg = dec[nb];
        x.segp = ~s_dp[id];
      end else begin
        x.an = 4'hF; x.seg = 7'h7F; x.segp = 1'b1;
      end
      x.ce1  = (e % DIV) == DIV - 1;
      x.ce10 = x.ce1 && ((e / DIV) % R) == R - 1;
      if (e == 1 || e % (DIV * N) == 0) begin
        s_dat = v_dat; s_dp = v_dp; s_blank = v_blank;
      end
      if (e == 1 || e % DIV == 0) s_bright = v_bright;
      k = e;
    end
    q.push_back(x);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst        = v_rst;
      bus.dat    = v_dat;
      bus.dp     = v_dp;
      bus.blank  = v_blank;
      bus.bright = v_bright;
      model();
    end
  endtask

  initial begin : monitor
    exp_t want, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        want = q.pop_front();
        got  = {bus.AN, bus.seg, bus.seg_P, bus.ce1ms, bus.ce10ms};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got AN=%h seg=%h P=%b ce1=%b ce10=%b, want AN=%h seg=%h P=%b ce1=%b ce10=%b",
                   $time, got.an, got.seg, got.segp, got.ce1, got.ce10,
                   want.an, want.seg, want.segp, want.ce1, want.ce10);
        end
      end
    end
  end

  initial begin : stim
    v_dat = 16'h1A3F; v_dp = 4'b0100; v_blank = '0; v_bright = 2'd3;
    v_rst = 1'b1;
    cyc(3);
    v_rst = 1'b0;
    cyc(192);

    v_bright = 2'd0; cyc(128);
    v_bright = 2'd1; cyc(128);
    v_bright = 2'd3;

    while (((k / DIV) % N) != 1) cyc(1);
    cyc(3);
    v_dat = 16'($urandom);
    cyc(160);

    v_blank = 4'b1000; cyc(128);
    v_blank = '0;

    v_dat = 16'h0005; v_dp = 4'b0000; cyc(128);
    v_dp = 4'b0100; cyc(128);

    v_dat = 16'h1A3F;
    while (!(((k / DIV) % N) == 2 && (k % DIV) == 5)) cyc(1);
    v_rst = 1'b1; cyc(1);
    v_rst = 1'b0; cyc(96);

    repeat (40) begin
      v_dat    = 16'($urandom);
      v_dp     = 4'($urandom);
      v_blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      v_bright = 2'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        v_rst = 1'b1; cyc(1); v_rst = 1'b0;
      end
      cyc($urandom_range(1, 90));
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
